// File: rtl/pcss_inf_bridge.sv
// Bridges a 64-bit AXI-Stream host port to the 16-bit East link of pcss_top and drives tik.
// Build option: define PARITY_CHECK_EN to parity-check chip->host flits and reject bad ones.
module pcss_inf_bridge #(
  parameter int DATA_WIDTH     = 64,
  parameter int CHIPDATA_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_send_tdata,
  input  logic                      S_AXIS_send_tvalid,
  input  logic                      S_AXIS_send_tlast,
  input  logic [DATA_WIDTH/8-1:0]   S_AXIS_send_tkeep,
  output logic                      S_AXIS_send_tready,
  output logic [DATA_WIDTH-1:0]     M_AXIS_recv_tdata,
  output logic                      M_AXIS_recv_tvalid,
  output logic                      M_AXIS_recv_tlast,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_recv_tkeep,
  input  logic                      M_AXIS_recv_tready,
  output logic                      tik,
  output logic [CHIPDATA_WIDTH-1:0] recv_data_in_E,
  output logic                      recv_data_valid_E,
  output logic                      recv_data_par_E,
  input  logic                      recv_data_ready_E,
  input  logic                      recv_data_err_E,
  input  logic [CHIPDATA_WIDTH-1:0] send_data_out_E,
  input  logic                      send_data_valid_E,
  input  logic                      send_data_par_E,
  output logic                      send_data_ready_E,
  output logic                      send_data_err_E
);
  localparam int         SH         = $clog2(CHIPDATA_WIDTH);
  localparam int         RX_SHIFT_W = DATA_WIDTH - CHIPDATA_WIDTH;
  localparam logic [1:0] LAST_FLIT  = 2'(DATA_WIDTH / CHIPDATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SEND, TIK} tx_state_t;

  tx_state_t                 state, state_d;
  logic [DATA_WIDTH-1:0]     tx_word, tx_word_d;
  logic [1:0]                flit_idx, flit_idx_d, prev_idx;
  logic [CHIPDATA_WIDTH-1:0] tik_cnt, tik_cnt_d, tik_len;
  logic                      xfer_q, retry, host_accept, is_cmd, flit_xfer;

  // A chip error refers to the flit moved last cycle; while it is being
  // handled no new host word may enter, or the rewound flit would be lost.
  assign retry              = xfer_q & recv_data_err_E;
  assign S_AXIS_send_tready = (state == IDLE) & ~retry;
  assign host_accept        = S_AXIS_send_tvalid & S_AXIS_send_tready;
  assign is_cmd             = S_AXIS_send_tdata[DATA_WIDTH-1 -: CHIPDATA_WIDTH] == '1;
  assign tik_len            = S_AXIS_send_tdata[CHIPDATA_WIDTH-1:0];

  // Flit 0 is the most significant slice of the word.
  assign recv_data_in_E    = tx_word[{~flit_idx, {SH{1'b0}}} +: CHIPDATA_WIDTH];
  assign recv_data_valid_E = (state == SEND);
  assign recv_data_par_E   = ^recv_data_in_E;
  assign flit_xfer         = recv_data_valid_E & recv_data_ready_E;
  assign tik               = (state == TIK);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state;
    tx_word_d  = tx_word;
    flit_idx_d = flit_idx;
    tik_cnt_d  = tik_cnt;
    unique case (state)
      IDLE: begin
        if (retry) begin
          state_d    = SEND;
          flit_idx_d = prev_idx;
        end else if (host_accept) begin
          if (is_cmd) begin
            state_d   = TIK;
            tik_cnt_d = (tik_len == '0) ? CHIPDATA_WIDTH'(1) : tik_len;
          end else begin
            state_d    = SEND;
            tx_word_d  = S_AXIS_send_tdata;
            flit_idx_d = '0;
          end
        end
      end
      SEND: begin
        // A flit offered in the retry cycle is void; the chip flagged the previous one.
        if (retry) begin
          flit_idx_d = prev_idx;
        end else if (flit_xfer) begin
          if (flit_idx == LAST_FLIT) state_d = IDLE;
          else flit_idx_d = flit_idx + 2'd1;
        end
      end
      TIK: begin
        if (tik_cnt <= CHIPDATA_WIDTH'(1)) state_d = IDLE;
        else tik_cnt_d = tik_cnt - CHIPDATA_WIDTH'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_word  <= '0;
      flit_idx <= '0;
      prev_idx <= '0;
      tik_cnt  <= '0;
      xfer_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state    <= state_d;
      tx_word  <= tx_word_d;
      flit_idx <= flit_idx_d;
      tik_cnt  <= tik_cnt_d;
      xfer_q   <= flit_xfer & ~retry;
      if (flit_xfer) prev_idx <= flit_idx;
    end
  end

  logic [RX_SHIFT_W-1:0] rx_shift;
  logic [1:0]            rx_cnt;
  logic                  rx_full, rx_take, rx_good, flit_bad, unused_ok;

  // The next word may start arriving in the cycle the host drains the pending one.
  assign send_data_ready_E  = ~rx_full | M_AXIS_recv_tready;
  assign rx_take            = send_data_valid_E & send_data_ready_E;
  assign rx_good            = rx_take & ~flit_bad;
  assign M_AXIS_recv_tvalid = rx_full;
  assign M_AXIS_recv_tlast  = rx_full;
  assign M_AXIS_recv_tkeep  = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift          <= '0;
      rx_cnt            <= '0;
      rx_full           <= 1'b0;
      M_AXIS_recv_tdata <= '0;
    end else begin
      if (M_AXIS_recv_tready) rx_full <= 1'b0;
      if (rx_good) begin
        if (rx_cnt == LAST_FLIT) begin
          M_AXIS_recv_tdata <= {rx_shift, send_data_out_E};
          rx_full           <= 1'b1;
          rx_cnt            <= '0;
        end else begin
          rx_shift <= {rx_shift[RX_SHIFT_W-CHIPDATA_WIDTH-1:0], send_data_out_E};
          rx_cnt   <= rx_cnt + 2'd1;
        end
      end
    end
  end

`ifdef PARITY_CHECK_EN
  logic err_q;

  assign flit_bad        = (^send_data_out_E) ^ send_data_par_E;
  assign send_data_err_E = err_q;
  assign unused_ok       = &{1'b0, S_AXIS_send_tlast, S_AXIS_send_tkeep};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= rx_take & flit_bad;
  end
`else
  assign flit_bad        = 1'b0;
  assign send_data_err_E = 1'b0;
  assign unused_ok       = &{1'b0, S_AXIS_send_tlast, S_AXIS_send_tkeep, send_data_par_E};
`endif

endmodule

// File: tb/tb_pcss_inf_bridge.sv
// Directed bench for pcss_inf_bridge: TX flit split/retry, tik command, RX packing, parity, reset.
// Expected flits and words are queued when stimulus is driven and popped when the DUT produces them.
module tb_pcss_inf_bridge;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] S_AXIS_send_tdata;
  logic        S_AXIS_send_tvalid;
  logic        S_AXIS_send_tlast;
  logic [7:0]  S_AXIS_send_tkeep;
  logic        S_AXIS_send_tready;
  logic [63:0] M_AXIS_recv_tdata;
  logic        M_AXIS_recv_tvalid;
  logic        M_AXIS_recv_tlast;
  logic [7:0]  M_AXIS_recv_tkeep;
  logic        M_AXIS_recv_tready;
  logic        tik;
  logic [15:0] recv_data_in_E;
  logic        recv_data_valid_E;
  logic        recv_data_par_E;
  logic        recv_data_ready_E;
  logic        recv_data_err_E;
  logic [15:0] send_data_out_E;
  logic        send_data_valid_E;
  logic        send_data_par_E;
  logic        send_data_ready_E;
  logic        send_data_err_E;

  int checks   = 0;
  int failures = 0;

  logic [15:0] flit_q[$];
  logic [63:0] word_q[$];
  logic [15:0] flit_exp;

  always #5 clk = ~clk;

  pcss_inf_bridge #(.DATA_WIDTH(64), .CHIPDATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_send_tdata(S_AXIS_send_tdata), .S_AXIS_send_tvalid(S_AXIS_send_tvalid),
    .S_AXIS_send_tlast(S_AXIS_send_tlast), .S_AXIS_send_tkeep(S_AXIS_send_tkeep),
    .S_AXIS_send_tready(S_AXIS_send_tready),
    .M_AXIS_recv_tdata(M_AXIS_recv_tdata), .M_AXIS_recv_tvalid(M_AXIS_recv_tvalid),
    .M_AXIS_recv_tlast(M_AXIS_recv_tlast), .M_AXIS_recv_tkeep(M_AXIS_recv_tkeep),
    .M_AXIS_recv_tready(M_AXIS_recv_tready),
    .tik(tik),
    .recv_data_in_E(recv_data_in_E), .recv_data_valid_E(recv_data_valid_E),
    .recv_data_par_E(recv_data_par_E), .recv_data_ready_E(recv_data_ready_E),
    .recv_data_err_E(recv_data_err_E),
    .send_data_out_E(send_data_out_E), .send_data_valid_E(send_data_valid_E),
    .send_data_par_E(send_data_par_E), .send_data_ready_E(send_data_ready_E),
    .send_data_err_E(send_data_err_E)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && recv_data_valid_E && recv_data_ready_E) begin
      if (flit_q.size() == 0) begin
        check("tx_unexpected_flit", 64'(1), 64'(0));
      end else begin
        flit_exp = flit_q.pop_front();
        check("tx_flit", 64'(recv_data_in_E), 64'(flit_exp));
        check("tx_par", 64'(recv_data_par_E), 64'(^flit_exp));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && M_AXIS_recv_tvalid && M_AXIS_recv_tready) begin
      if (word_q.size() == 0) begin
        check("rx_unexpected_word", 64'(1), 64'(0));
      end else begin
        check("rx_word", M_AXIS_recv_tdata, word_q.pop_front());
        check("rx_tlast", 64'(M_AXIS_recv_tlast), 64'(1));
      end
    end
  end

  task automatic send_word(input logic [63:0] w);
    bit ok = 1'b0;
    S_AXIS_send_tdata  = w;
    S_AXIS_send_tvalid = 1'b1;
    if (w[63:48] != 16'hFFFF)
      for (int i = 0; i < 4; i++) flit_q.push_back(w[63-16*i -: 16]);
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = S_AXIS_send_tready;
      drive_edge();
    end
    S_AXIS_send_tvalid = 1'b0;
    check("host_accept", 64'(ok), 64'(1));
  endtask

  task automatic chip_send(input logic [15:0] f, input logic p);
    bit ok = 1'b0;
    send_data_out_E   = f;
    send_data_par_E   = p;
    send_data_valid_E = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = send_data_ready_E;
      drive_edge();
    end
    send_data_valid_E = 1'b0;
    check("chip_flit_accept", 64'(ok), 64'(1));
  endtask

  task automatic wait_tx_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = S_AXIS_send_tready && !recv_data_valid_E;
      drive_edge();
    end
    check("tx_idle", 64'(ok), 64'(1));
  endtask

  initial begin
    int hi, vl;
    rst_n              = 1'b0;
    S_AXIS_send_tdata  = '0;
    S_AXIS_send_tvalid = 1'b0;
    S_AXIS_send_tlast  = 1'b1;
    S_AXIS_send_tkeep  = 8'hFF;
    M_AXIS_recv_tready = 1'b1;
    recv_data_ready_E  = 1'b1;
    recv_data_err_E    = 1'b0;
    send_data_out_E    = '0;
    send_data_valid_E  = 1'b0;
    send_data_par_E    = 1'b0;

    // Reset values
    drive_edge();
    @(negedge clk);
    check("rst_tready", 64'(S_AXIS_send_tready), 64'(1));
    check("rst_chip_ready", 64'(send_data_ready_E), 64'(1));
    check("rst_tkeep", 64'(M_AXIS_recv_tkeep), 64'hFF);
    check("rst_tvalid", 64'(M_AXIS_recv_tvalid), 64'(0));
    check("rst_tlast", 64'(M_AXIS_recv_tlast), 64'(0));
    check("rst_tdata", M_AXIS_recv_tdata, 64'(0));
    check("rst_tik", 64'(tik), 64'(0));
    check("rst_flit_valid", 64'(recv_data_valid_E), 64'(0));
    check("rst_flit_data", 64'(recv_data_in_E), 64'(0));
    check("rst_flit_par", 64'(recv_data_par_E), 64'(0));
    check("rst_chip_err", 64'(send_data_err_E), 64'(0));
    drive_edge();
    rst_n = 1'b1;
    drive_edge();

    // TX at full speed: four consecutive flits, tready low for exactly four cycles
    send_word(64'h0123_4567_89AB_CDEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("tx_tready_busy", 64'(S_AXIS_send_tready), 64'(0));
      check("tx_valid_burst", 64'(recv_data_valid_E), 64'(1));
      drive_edge();
    end
    @(negedge clk);
    check("tx_tready_back", 64'(S_AXIS_send_tready), 64'(1));
    check("tx_valid_done", 64'(recv_data_valid_E), 64'(0));
    drive_edge();

    // TX backpressure on flit 2, then a chip error after flit 3
    send_word(64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    drive_edge();
    recv_data_ready_E = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("tx_hold_data", 64'(recv_data_in_E), 64'h4567);
      check("tx_hold_valid", 64'(recv_data_valid_E), 64'(1));
      drive_edge();
    end
    recv_data_ready_E = 1'b1;
    @(negedge clk);
    drive_edge();
    @(negedge clk);
    drive_edge();
    recv_data_ready_E = 1'b0;
    recv_data_err_E   = 1'b1;
    flit_q.push_front(16'h89AB);
    @(negedge clk);
    check("tx_err_cycle_data", 64'(recv_data_in_E), 64'hCDEF);
    check("tx_err_cycle_tready", 64'(S_AXIS_send_tready), 64'(0));
    drive_edge();
    recv_data_err_E   = 1'b0;
    recv_data_ready_E = 1'b1;
    @(negedge clk);
    check("tx_resend_data", 64'(recv_data_in_E), 64'h89AB);
    drive_edge();
    wait_tx_idle();

    // Tik commands: N=3 then N=0
    send_word(64'hFFFF_0000_0000_0003);
    hi = 0; vl = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) check("tik_rise", 64'(tik), 64'(1));
      hi += int'(tik);
      vl += int'(recv_data_valid_E);
      drive_edge();
    end
    check("tik_len_3", 64'(hi), 64'(3));
    check("tik_no_flit", 64'(vl), 64'(0));
    send_word(64'hFFFF_0000_0000_0000);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hi += int'(tik);
      drive_edge();
    end
    check("tik_len_0", 64'(hi), 64'(1));
    check("tik_tready_back", 64'(S_AXIS_send_tready), 64'(1));

    // RX packing with host backpressure
    M_AXIS_recv_tready = 1'b0;
    word_q.push_back(64'hAAAA_5555_0000_FFFF);
    chip_send(16'hAAAA, ^16'hAAAA);
    chip_send(16'h5555, ^16'h5555);
    chip_send(16'h0000, ^16'h0000);
    chip_send(16'hFFFF, ^16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rx_pending_valid", 64'(M_AXIS_recv_tvalid), 64'(1));
      check("rx_pending_data", M_AXIS_recv_tdata, 64'hAAAA_5555_0000_FFFF);
      check("rx_pending_tlast", 64'(M_AXIS_recv_tlast), 64'(1));
      check("rx_chip_stalled", 64'(send_data_ready_E), 64'(0));
      drive_edge();
    end

    // Host drains the word in the same cycle the first all-ones flit lands
    M_AXIS_recv_tready = 1'b1;
    word_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 4; i++) chip_send(16'hFFFF, 1'b0);
    @(negedge clk);
    drive_edge();
    @(negedge clk);
    check("rx_drained", 64'(M_AXIS_recv_tvalid), 64'(0));
    drive_edge();

    // Chip flit with wrong parity
    word_q.push_back(64'h1234_5678_9ABC_DEF0);
    chip_send(16'h1234, ^16'h1234);
    chip_send(16'h5678, ~(^16'h5678));
`ifdef PARITY_CHECK_EN
    @(negedge clk);
    check("par_err_pulse", 64'(send_data_err_E), 64'(1));
    drive_edge();
    @(negedge clk);
    check("par_err_end", 64'(send_data_err_E), 64'(0));
    check("par_no_word_yet", 64'(M_AXIS_recv_tvalid), 64'(0));
    drive_edge();
    chip_send(16'h5678, ^16'h5678);
`else
    @(negedge clk);
    check("par_err_tied", 64'(send_data_err_E), 64'(0));
    drive_edge();
`endif
    chip_send(16'h9ABC, ^16'h9ABC);
    chip_send(16'hDEF0, ^16'hDEF0);
    @(negedge clk);
    drive_edge();

    // Reset in the middle of a partial RX word and a stalled TX word
    chip_send(16'hAAAA, ^16'hAAAA);
    chip_send(16'hBBBB, ^16'hBBBB);
    recv_data_ready_E = 1'b0;
    send_word(64'h1111_2222_3333_4444);
    @(negedge clk);
    check("mid_tx_valid", 64'(recv_data_valid_E), 64'(1));
    check("mid_tx_data", 64'(recv_data_in_E), 64'h1111);
    drive_edge();
    rst_n = 1'b0;
    flit_q.delete();
    @(negedge clk);
    check("mid_rst_flit_valid", 64'(recv_data_valid_E), 64'(0));
    check("mid_rst_tready", 64'(S_AXIS_send_tready), 64'(1));
    check("mid_rst_rx_valid", 64'(M_AXIS_recv_tvalid), 64'(0));
    drive_edge();
    rst_n = 1'b1;
    recv_data_ready_E = 1'b1;
    drive_edge();
    word_q.push_back(64'h0001_0002_0003_0004);
    chip_send(16'h0001, ^16'h0001);
    chip_send(16'h0002, ^16'h0002);
    chip_send(16'h0003, ^16'h0003);
    chip_send(16'h0004, ^16'h0004);
    send_word(64'h5555_6666_7777_8888);
    wait_tx_idle();

    check("flit_queue_empty", 64'(flit_q.size()), 64'(0));
    check("word_queue_empty", 64'(word_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
